// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty flags and a registered read port.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with an err_clr input.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               winc,
    input  logic [DATA_WIDTH-1:0]              w_data,
    input  logic                               rinc,
    output logic [DATA_WIDTH-1:0]              r_data,
    output logic                               r_valid,
    output logic                               wfull,
    output logic                               rempty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                               err_clr,
    output logic                               overflow,
    output logic                               underflow
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

`ifndef SYNTHESIS
    initial begin
        if (FIFO_DEPTH < 2)
            $error("sync_fifo_param: FIFO_DEPTH=%0d must be >= 2", FIFO_DEPTH);
        if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH)
            $error("sync_fifo_param: AF_THRESH=%0d outside 1..%0d", AF_THRESH, FIFO_DEPTH);
        if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1)
            $error("sync_fifo_param: AE_THRESH=%0d outside 0..%0d", AE_THRESH, FIFO_DEPTH - 1);
    end
`endif

    // Flags decode from the count register only, so they never see winc/rinc combinationally.
    always_comb begin
        wfull        = (r_count == CNT_FULL);
        rempty       = (r_count == '0);
        almost_full  = (r_count >= CNT_AF);
        almost_empty = (r_count <= CNT_AE);
        fill_level   = r_count;
        w_wr_ok      = winc && !wfull;
        w_rd_ok      = rinc && !rempty;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_ok;
            if (w_wr_ok)
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
            if (w_rd_ok) begin
                r_data <= r_mem[r_rptr];
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // err_clr wins over a set event in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=6, AF=5, AE=1) against a queue-based reference model.
// Covers SYNC_FIFO_ERR_FLAGS_EN when the macro is defined for both files.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          winc = 1'b0;
    logic          rinc = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          wfull;
    logic          rempty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    fill_level;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .w_data       (w_data),
        .rinc         (rinc),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .wfull        (wfull),
        .rempty       (rempty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_level   (fill_level)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain queue of stored words plus expected registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rdata = '0;
    logic          exp_rvalid = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        check_eq({tag, ":fill"},   32'(fill_level),   32'(n));
        check_eq({tag, ":wfull"},  32'(wfull),        32'(n == DEPTH));
        check_eq({tag, ":rempty"}, 32'(rempty),       32'(n == 0));
        check_eq({tag, ":afull"},  32'(almost_full),  32'(n >= AF));
        check_eq({tag, ":aempty"}, 32'(almost_empty), 32'(n <= AE));
        check_eq({tag, ":rvalid"}, 32'(r_valid),      32'(exp_rvalid));
        check_eq({tag, ":rdata"},  32'(r_data),       32'(exp_rdata));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check_eq({tag, ":ovf"},    32'(overflow),     32'(exp_ovf));
        check_eq({tag, ":unf"},    32'(underflow),    32'(exp_unf));
`endif
    endtask

    // One clock: drive on negedge, model the edge, check #1 after posedge.
    task automatic cyc(input string tag, input logic wi, input logic [DW-1:0] wd,
                       input logic ri, input logic clr);
        logic was_full, was_empty;
        @(negedge clk);
        winc = wi; w_data = wd; rinc = ri; err_clr = clr;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (clr) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (wi && was_full)  exp_ovf = 1'b1;
            if (ri && was_empty) exp_unf = 1'b1;
        end
        exp_rvalid = 1'b0;
        if (ri && !was_empty) begin
            exp_rdata  = q.pop_front();
            exp_rvalid = 1'b1;
        end
        if (wi && !was_full) q.push_back(wd);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        exp_rdata  = '0;
        exp_rvalid = 1'b0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Fill and drain
        for (int k = 1; k <= DEPTH; k++) cyc("fill", 1'b1, DW'(k * 17), 1'b0, 1'b0);
        for (int k = 1; k <= DEPTH; k++) cyc("drain", 1'b0, '0, 1'b1, 1'b0);
        check_eq("drain_last", 32'(r_data), 32'h66);
        idle("drain_idle");

        // 2. Wrap-around on depth 6
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) cyc("wrap_w", 1'b1, DW'(r * 4 + k), 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                cyc("wrap_r", 1'b0, '0, 1'b1, 1'b0);
                check_eq("wrap_seq", 32'(r_data), 32'(r * 4 + k));
            end
        end

        // 3. Full with simultaneous requests
        for (int k = 0; k < DEPTH; k++) cyc("f3_fill", 1'b1, DW'(8'hC0 + k), 1'b0, 1'b0);
        cyc("full_both", 1'b1, 8'hAA, 1'b1, 1'b0);
        check_eq("full_both_data", 32'(r_data), 32'hC0);
        check_eq("full_both_lvl", 32'(fill_level), 32'd5);
        for (int k = 0; k < DEPTH - 1; k++) cyc("f3_drain", 1'b0, '0, 1'b1, 1'b0);
        check_eq("no_aa_stored", 32'(r_data), 32'hC5);

        // 4. Empty with simultaneous requests
        cyc("empty_both", 1'b1, 8'h5C, 1'b1, 1'b0);
        check_eq("empty_both_rv", 32'(r_valid), 32'd0);
        cyc("empty_read", 1'b0, '0, 1'b1, 1'b0);
        check_eq("empty_read_data", 32'(r_data), 32'h5C);

        // 5. Reset mid-operation
        cyc("r5_w", 1'b1, 8'h31, 1'b0, 1'b0);
        cyc("r5_w", 1'b1, 8'h32, 1'b0, 1'b0);
        cyc("r5_r", 1'b0, '0, 1'b1, 1'b0);
        cyc("r5_w", 1'b1, 8'h33, 1'b0, 1'b0);
        cyc("r5_w", 1'b1, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        winc = 1'b0; rinc = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst_w", 1'b1, 8'h9E, 1'b0, 1'b0);
        cyc("post_rst_r", 1'b0, '0, 1'b1, 1'b0);
        check_eq("post_rst_data", 32'(r_data), 32'h9E);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        // 6. Sticky error flags
        for (int k = 0; k < DEPTH; k++) cyc("e_fill", 1'b1, DW'(8'h40 + k), 1'b0, 1'b0);
        cyc("ovf_set", 1'b1, 8'hEE, 1'b0, 1'b0);
        idle("ovf_hold");
        check_eq("ovf_held", 32'(overflow), 32'd1);
        cyc("ovf_clr_set", 1'b1, 8'hEF, 1'b0, 1'b1);
        check_eq("ovf_clr_prio", 32'(overflow), 32'd0);
        for (int k = 0; k < DEPTH; k++) cyc("e_drain", 1'b0, '0, 1'b1, 1'b0);
        check_eq("ovf_contents", 32'(r_data), 32'h45);
        cyc("unf_set", 1'b0, '0, 1'b1, 1'b0);
        check_eq("unf_flag", 32'(underflow), 32'd1);
        cyc("unf_clr", 1'b0, '0, 1'b0, 1'b1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
